// File: rtl/alu_ctrl_pkg.sv
// Shared op code table and state encoding for the
// ALU control decoder and the execute-stage ALU.
package alu_ctrl_pkg;

  localparam int WIDTH      = 32;
  localparam int MUL_CYCLES = 32;

  localparam logic [3:0] OP_AND     = 4'b0000;
  localparam logic [3:0] OP_OR      = 4'b0001;
  localparam logic [3:0] OP_ADD     = 4'b0010;
  localparam logic [3:0] OP_SUB     = 4'b0110;
  localparam logic [3:0] OP_SLT     = 4'b0111;
  localparam logic [3:0] OP_MUL     = 4'b1000;
  localparam logic [3:0] OP_INVALID = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_seq_exec_mul.sv
// Shift-add multiply datapath: one multiplier bit per step.
// acc_next_o already includes the current step's partial product.
module seq_mul_core
  import alu_ctrl_pkg::*;
#(
  parameter int W  = WIDTH,
  parameter int NC = MUL_CYCLES
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic         step_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] acc_next_o,
  output logic         last_o
);

  localparam int CW = $clog2(NC);

  logic [W-1:0]  mcand_q, mplier_q, acc_q;
  logic [CW-1:0] cnt_q;

  assign acc_next_o = mplier_q[0] ? acc_q + mcand_q : acc_q;
  assign last_o     = (cnt_q == CW'(NC - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (load_i) begin
      mcand_q  <= a_i;
      mplier_q <= b_i;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (step_i) begin
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      acc_q    <= acc_next_o;
      cnt_q    <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/alu_seq_exec.sv
// Execute-stage ALU: single-cycle logic/arith ops plus a
// 32-cycle iterative multiply behind a start/done handshake.
module alu_seq_exec
  import alu_ctrl_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             illegal_o
);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             ill_q, ill_d;
  logic             done_q, done_d;
  logic             mul_load, mul_step, mul_last;
  logic [WIDTH-1:0] mul_acc;
  logic [WIDTH-1:0] alu_res;
  logic             alu_legal;

  seq_mul_core #(.W(WIDTH), .NC(MUL_CYCLES)) u_mul (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (mul_load),
    .step_i     (mul_step),
    .a_i        (src1_i),
    .b_i        (src2_i),
    .acc_next_o (mul_acc),
    .last_o     (mul_last)
  );

  always_comb begin
    alu_res   = '0;
    alu_legal = 1'b1;
    case (ALUCtrl_i)
      OP_AND:  alu_res = src1_i & src2_i;
      OP_OR:   alu_res = src1_i | src2_i;
      OP_ADD:  alu_res = src1_i + src2_i;
      OP_SUB:  alu_res = src1_i - src2_i;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}},
                          $signed(src1_i) < $signed(src2_i)};
      default: alu_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    ill_d    = ill_q;
    done_d   = 1'b0;
    mul_load = 1'b0;
    mul_step = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start_i && ALUCtrl_i == OP_MUL) begin
          mul_load = 1'b1;
          state_d  = S_MUL;
        end else if (start_i) begin
          result_d = alu_res;
          zero_d   = (alu_res == '0);
          ill_d    = ~alu_legal;
          done_d   = 1'b1;
          state_d  = S_DONE;
        end
      end
      S_MUL: begin
        mul_step = 1'b1;
        if (mul_last) begin
          result_d = mul_acc;
          zero_d   = (mul_acc == '0);
          ill_d    = 1'b0;
          done_d   = 1'b1;
          state_d  = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      zero_q   <= 1'b1;
      ill_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ill_q    <= ill_d;
      done_q   <= done_d;
    end
  end

  assign busy_o    = (state_q == S_MUL);
  assign done_o    = done_q;
  assign result_o  = result_q;
  assign zero_o    = zero_q;
  assign illegal_o = ill_q;

endmodule

// File: tb/tb_alu_seq_exec.sv
// Directed-vector bench for alu_seq_exec.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_alu_seq_exec;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        busy, done, zero, ill;
  logic [31:0] res;

  int vectors = 0;
  int miscompares = 0;

  alu_seq_exec dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (start),
    .ALUCtrl_i (op),
    .src1_i    (a),
    .src2_i    (b),
    .busy_o    (busy),
    .done_o    (done),
    .result_o  (res),
    .zero_o    (zero),
    .illegal_o (ill)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; start = 0; op = 4'b0010; a = 0; b = 0;
    tick(); tick();
    rst = 0;
    vectors++;
    if (res !== 32'h0 || zero !== 1'b1 || busy !== 1'b0 ||
        done !== 1'b0 || ill !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: res=%h zero=%b busy=%b done=%b ill=%b, want 0/1/0/0/0",
               res, zero, busy, done, ill);
    end
  endtask

  task automatic sc_op(input string name, input logic [3:0] o,
                       input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] exp_r, input logic exp_ill);
    op = o; a = x; b = y; start = 1;
    tick();
    vectors++;
    if (done !== 1'b1 || res !== exp_r || zero !== (exp_r == 0) ||
        ill !== exp_ill || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: done=%b res=%h zero=%b ill=%b busy=%b, want 1/%h/%b/%b/0",
               name, done, res, zero, ill, busy, exp_r, exp_r == 0, exp_ill);
    end
  endtask

  task automatic test_back_to_back();
    sc_op("b2b_add", 4'b0010, 32'd7, 32'd5, 32'd12, 0);
    sc_op("b2b_sub", 4'b0110, 32'd5, 32'd7, 32'hFFFF_FFFE, 0);
    sc_op("b2b_and", 4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 0);
    sc_op("b2b_slt", 4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd1, 0);
    start = 0; op = 4'b0001; a = 32'hFF; b = 0;
    tick();
    vectors++;
    if (done !== 1'b0 || res !== 32'd1 || zero !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_hold: done=%b res=%h zero=%b, want 0/1/0",
               done, res, zero);
    end
  endtask

  task automatic test_slt_overflow();
    sc_op("slt_ovf1", 4'b0111, 32'h8000_0000, 32'd1, 32'd1, 0);
    sc_op("slt_ovf2", 4'b0111, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd0, 0);
    sc_op("sub_zero", 4'b0110, 32'd3, 32'd3, 32'd0, 0);
    sc_op("or", 4'b0001, 32'h1200_0000, 32'h0000_0034, 32'h1200_0034, 0);
    start = 0;
    tick();
  endtask

  task automatic run_mul(input string name, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] exp_r,
                         input bit poke);
    int n;
    int busy_cnt;
    op = 4'b1000; a = x; b = y; start = 1;
    tick();
    start = 0;
    n = 0;
    busy_cnt = 0;
    while (done !== 1'b1 && n < 40) begin
      if (busy === 1'b1) busy_cnt++;
      if (poke) begin
        start = (n == 5 || n == 10 || n == 20);
        op = (n == 10) ? 4'b1000 : 4'b0010;
        a = 32'hDEAD_0000 + n; b = 32'd3;
      end
      tick();
      n++;
    end
    start = 0;
    vectors++;
    if (n !== 32 || busy_cnt !== 32 || res !== exp_r ||
        zero !== (exp_r == 0) || ill !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: lat=%0d busy_cycles=%0d res=%h zero=%b ill=%b busy=%b, want 32/32/%h/%b/0/0",
               name, n, busy_cnt, res, zero, ill, busy, exp_r, exp_r == 0);
    end
    tick();
    vectors++;
    if (done !== 1'b0 || res !== exp_r || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_after: done=%b res=%h busy=%b, want 0/%h/0",
               name, done, res, busy, exp_r);
    end
  endtask

  task automatic test_mul_timing();
    run_mul("mul_timing", 32'd1234, 32'd5678, 32'd7006652, 1);
  endtask

  task automatic test_mul_wrap();
    run_mul("mul_m1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    run_mul("mul_wrap0", 32'h0001_0000, 32'h0001_0000, 32'h0, 0);
    run_mul("mul_neg", 32'hFFFF_FFFD, 32'd4, 32'hFFFF_FFF4, 0);
  endtask

  task automatic test_illegal();
    sc_op("ill_1111", 4'b1111, 32'd9, 32'd9, 32'd0, 1);
    sc_op("ill_0011", 4'b0011, 32'd1, 32'd2, 32'd0, 1);
    sc_op("legal_after", 4'b0010, 32'd40, 32'd2, 32'd42, 0);
    start = 0;
    tick();
  endtask

  task automatic test_reset_abort();
    int seen;
    op = 4'b1000; a = 32'd5; b = 32'd6; start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 10; i++) tick();
    rst = 1;
    tick();
    rst = 0;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || res !== 32'h0 ||
        zero !== 1'b1 || ill !== 1'b0) begin
      miscompares++;
      $display("FAIL abort: busy=%b done=%b res=%h zero=%b ill=%b, want 0/0/0/1/0",
               busy, done, res, zero, ill);
    end
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    vectors++;
    if (seen !== 0 || res !== 32'h0) begin
      miscompares++;
      $display("FAIL abort_quiet: stray cycles=%0d res=%h, want 0/0", seen, res);
    end
    rst = 1; start = 1; op = 4'b0010; a = 32'd1; b = 32'd1;
    tick();
    rst = 0; start = 0;
    vectors++;
    if (done !== 1'b0 || res !== 32'h0 || zero !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_wins: done=%b res=%h zero=%b, want 0/0/1",
               done, res, zero);
    end
    tick();
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_wins_drop: done=%b busy=%b, want 0/0", done, busy);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_slt_overflow();
    test_mul_timing();
    test_mul_wrap();
    test_illegal();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_seq_exec.md
Name: alu_seq_exec

Overview:
- Execute-stage ALU, directly downstream of the ALU control decoder.
- Consumes the 4-bit ALU control code and two 32-bit operands, and returns a registered result with a start/done handshake.
- Single-cycle ops (AND/OR/ADD/SUB/SLT) complete in 1 cycle.
- New MUL code runs an iterative shift-add multiply over 32 cycles; the datapath stalls on busy_o.

Parameters:
- WIDTH, 32, operand/result width.
- MUL_CYCLES, 32, multiply iterations; equals WIDTH, and one bit is processed per cycle.

Ports:
- clk_i  input  1  system clock; all state changes on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- start_i  input  1  operation request; sampled only while busy_o=0.
- ALUCtrl_i  input  4  operation code.
- src1_i  input  WIDTH  operand A.
- src2_i  input  WIDTH  operand B.
- busy_o  output  1  high while a multiply is in progress.
- done_o  output  1  one-cycle pulse: result_o/zero_o/illegal_o just updated.
- result_o  output  WIDTH  registered result; held until the next completion.
- zero_o  output  1  registered (result_o==0).
- illegal_o  output  1  registered; 1 if the completed op code was unsupported.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. Reset → state IDLE, busy_o=0, done_o=0, result_o=0, zero_o=1, illegal_o=0.
- Op codes:
  - 0000 AND; 0001 OR; 0010 ADD (wrap mod 2^WIDTH, no overflow flag); 0110 SUB (A-B, wrap).
  - 0111 SLT: signed A<B → result 1, else 0; must be correct when A-B overflows.
  - 1000 MUL: low WIDTH bits of A*B; identical for signed and unsigned.
  - All other codes (incl. 1111, x) are illegal.
- States: IDLE, MUL, DONE.
- Accept rule: start_i is accepted on an edge where state is IDLE or DONE (busy_o=0). start_i during MUL is ignored, not queued.
- Single-cycle/illegal op accepted at edge E0:
  - At E0: result registered, state→DONE, done_o=1 for the cycle after E0.
  - Illegal code: result_o=0, zero_o=1, illegal_o=1.
- Back-to-back: start_i held high with single-cycle ops → one completion per cycle; done_o stays high, state remains DONE.
- MUL accepted at E0:
  - Latch A into multiplicand, B into multiplier, clear accumulator and counter; state→MUL, busy_o=1 from the cycle after E0.
  - Each edge in MUL: if multiplier LSB=1, add multiplicand to accumulator; shift multiplicand left and multiplier right; increment counter.
  - On the edge performing iteration MUL_CYCLES (E32): result_o←accumulator, state→DONE, busy_o=0, done_o=1. Latency = 32 cycles from accept to done.
- DONE with no start: next edge → IDLE, done_o=0; result_o/zero_o/illegal_o hold.
- Operand/code changes while in MUL have no effect, since the operands were latched at E0.
- Reset mid-multiply aborts: all outputs return to reset values next cycle, no done pulse, partial product discarded.
- Reset and start_i on the same edge: reset wins; the request is dropped.
- busy_o is a pure function of state (state==MUL), so there is no combinational path from inputs to busy_o or done_o.

Decomposition:
- Shared package alu_ctrl_pkg:
  - 4-bit op code constants: OP_AND=0000, OP_OR=0001, OP_ADD=0010, OP_SUB=0110, OP_SLT=0111, OP_MUL=1000, OP_INVALID=1111.
  - State encoding constants, so the upstream control decoder and this block share one op code table.
- One sub-module, seq_mul_core: the shift-add datapath plus counter, with load/step/last interface. The FSM, single-cycle ops and output registers stay in alu_seq_exec.

Test Plan:
- Reset then idle: rst_i=1 for 2 cycles → result_o=0, zero_o=1, busy_o=0, done_o=0, illegal_o=0.
- Single-cycle ops, back-to-back: start_i held 4 cycles with ADD 7+5, SUB 5-7, AND F0F0_F0F0&0FF0_0FF0, SLT -1<1 → done_o high 4 consecutive cycles; results 12, FFFF_FFFE, 00F0_00F0, 1.
- SLT overflow: A=8000_0000, B=0000_0001 → 1; A=7FFF_FFFF, B=FFFF_FFFF → 0; SUB 3-3 → result 0, zero_o=1.
- MUL timing: A=1234, B=5678 accepted at E0 → busy_o=1 for 32 cycles; done_o pulses once after E32 with result 7006652; start_i pulses during busy ignored.
- MUL wrap and signed: FFFF_FFFF*FFFF_FFFF → 0000_0001; 0001_0000*0001_0000 → 0, zero_o=1; -3*4 → FFFF_FFF4.
- Illegal code and reset abort: code 1111 → done_o=1, illegal_o=1, result_o=0. MUL started, then rst_i at iteration 10 → no done_o, busy_o=0 next cycle, outputs at reset values.
